// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin grant, one-cycle dispatch, held response.
// Optional opcode rejection (3'b100, 3'b111) is enabled by defining ALU_ARBITER_OPCHECK_EN.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic             id_q, last_q, zero_q, err_q;

    logic             grant_c, accept_c, capture_c, bad_op_c, drive_c;
    logic [WIDTH-1:0] sel_a_c, sel_b_c;
    logic [2:0]       sel_op_c;

    assign sel_a_c  = grant_c ? req1_a  : req0_a;
    assign sel_b_c  = grant_c ? req1_b  : req0_b;
    assign sel_op_c = grant_c ? req1_op : req0_op;

`ifdef ALU_ARBITER_OPCHECK_EN
    assign bad_op_c = (sel_op_c == 3'b100) || (sel_op_c == 3'b111);
`else
    assign bad_op_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, grant and handshake
    always_comb begin
        state_d    = state_q;
        grant_c    = ~last_q;
        accept_c   = 1'b0;
        capture_c  = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid && !req1_valid)      grant_c = 1'b0;
                else if (req1_valid && !req0_valid) grant_c = 1'b1;
                else                                grant_c = ~last_q;
                // Readies are gated by reset so nothing is offered while held in reset
                if (reset_n && (grant_c ? req1_valid : req0_valid)) begin
                    accept_c   = 1'b1;
                    req0_ready = ~grant_c;
                    req1_ready = grant_c;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                capture_c = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                if (id_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transaction latch and result capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 3'b000;
            id_q   <= 1'b0;
            last_q <= 1'b1;
            err_q  <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q    <= sel_a_c;
                b_q    <= sel_b_c;
                op_q   <= sel_op_c;
                id_q   <= grant_c;
                last_q <= grant_c;
                err_q  <= bad_op_c;
            end
            if (capture_c) begin
                res_q  <= err_q ? '0 : alu_result;
                zero_q <= err_q ? 1'b1 : alu_zero;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign drive_c     = busy && !err_q;
    assign alu_a       = drive_c ? a_q  : '0;
    assign alu_b       = drive_c ? b_q  : '0;
    assign alu_control = drive_c ? op_q : 3'b000;

    assign rsp0_valid  = (state_q == RESP) && !id_q;
    assign rsp1_valid  = (state_q == RESP) &&  id_q;
    assign rsp0_result = rsp0_valid ? res_q : '0;
    assign rsp1_result = rsp1_valid ? res_q : '0;
    assign rsp0_zero   = rsp0_valid && zero_q;
    assign rsp1_zero   = rsp1_valid && zero_q;
    assign rsp0_err    = rsp0_valid && err_q;
    assign rsp1_err    = rsp1_valid && err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single transactions plus tie, reset and backpressure sequences.
module tb_alu_arbiter;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic         rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_control;
    logic         alu_zero, busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    // Stand-in combinational ALU
    function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a & ~b;
            3'b100:  return a ^ b;
            3'b101:  return a << b[4:0];
            3'b110:  return a | b;
            default: return W'(a < b);
        endcase
    endfunction

    always_comb begin
        alu_result = alu_f(alu_control, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    typedef struct {
        bit           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] res;
        logic         zero;
        logic         err;
        int           hold;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_req(input bit id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op);
        if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
    endtask

    task automatic set_rdy(input bit id, input logic v);
        if (id) rsp1_ready = v;
        else    rsp0_ready = v;
    endtask

    function automatic logic rdy(input bit id);      return id ? req1_ready  : req0_ready;  endfunction
    function automatic logic rv(input bit id);       return id ? rsp1_valid  : rsp0_valid;  endfunction
    function automatic logic [W-1:0] rr(input bit id); return id ? rsp1_result : rsp0_result; endfunction
    function automatic logic rz(input bit id);       return id ? rsp1_zero   : rsp0_zero;   endfunction
    function automatic logic re(input bit id);       return id ? rsp1_err    : rsp0_err;    endfunction

    task automatic do_txn(input vec_t v);
        @(posedge clk); #1;
        set_req(v.id, 1'b1, v.a, v.b, v.op);
        @(negedge clk);
        chk("idle_ready", W'(rdy(v.id)), 1);
        chk("idle_busy", W'(busy), 0);
        @(posedge clk); #1;
        set_req(v.id, 1'b0, ~v.a, ~v.b, ~v.op);
        @(negedge clk);
        chk("exec_busy", W'(busy), 1);
        chk("exec_ctrl", W'(alu_control), v.err ? 0 : W'(v.op));
        chk("exec_a", alu_a, v.err ? '0 : v.a);
        chk("exec_b", alu_b, v.err ? '0 : v.b);
        chk("exec_rspv", W'(rv(v.id)), 0);
        @(negedge clk);
        chk("rsp_valid", W'(rv(v.id)), 1);
        chk("rsp_result", rr(v.id), v.res);
        chk("rsp_zero", W'(rz(v.id)), W'(v.zero));
        chk("rsp_err", W'(re(v.id)), W'(v.err));
        chk("rsp_other_valid", W'(rv(~v.id)), 0);
        chk("rsp_other_result", rr(~v.id), 0);
        for (int h = 0; h < v.hold; h++) begin
            // Other side requests and pokes its rsp_ready while this response is stalled
            set_req(~v.id, 1'b1, 32'd1, 32'd1, 3'b000);
            set_rdy(~v.id, 1'b1);
            @(negedge clk);
            chk("hold_valid", W'(rv(v.id)), 1);
            chk("hold_result", rr(v.id), v.res);
            chk("hold_busy", W'(busy), 1);
            chk("hold_other_ready", W'(rdy(~v.id)), 0);
            chk("hold_other_rspv", W'(rv(~v.id)), 0);
        end
        set_req(~v.id, 1'b0, '0, '0, 3'b000);
        set_rdy(~v.id, 1'b0);
        set_rdy(v.id, 1'b1);
        @(posedge clk); #1;
        set_rdy(v.id, 1'b0);
        @(negedge clk);
        chk("done_busy", W'(busy), 0);
        chk("done_rspv", W'(rv(v.id)), 0);
        chk("done_alu_a", alu_a, 0);
        @(negedge clk);
        chk("after_busy", W'(busy), 0);
        chk("after_other_rspv", W'(rv(~v.id)), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready0"}, W'(req0_ready), 0);
        chk({tag, "_ready1"}, W'(req1_ready), 0);
        chk({tag, "_busy"}, W'(busy), 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_ctrl"}, W'(alu_control), 0);
        chk({tag, "_rsp0v"}, W'(rsp0_valid), 0);
        chk({tag, "_rsp0r"}, rsp0_result, 0);
        chk({tag, "_rsp1v"}, W'(rsp1_valid), 0);
        chk({tag, "_flags"}, W'({rsp0_zero, rsp0_err, rsp1_zero, rsp1_err}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 32'd10, 32'd3, 3'b001, 32'd7, 1'b0, 1'b0, 5};
        vecs[2] = '{1'b0, 32'd6, 32'd6, 3'b001, 32'd0, 1'b1, 1'b0, 0};
        vecs[3] = '{1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 3'b010, 32'h0000_00F0, 1'b0, 1'b0, 0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 1'b1, 1'b0, 0};
`ifdef ALU_ARBITER_OPCHECK_EN
        vecs[5] = '{1'b1, 32'd3, 32'd4, 3'b111, 32'd0, 1'b1, 1'b1, 0};
        vecs[6] = '{1'b0, 32'd6, 32'd3, 3'b100, 32'd0, 1'b1, 1'b1, 1};
`else
        vecs[5] = '{1'b1, 32'd3, 32'd4, 3'b111, 32'd1, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b0, 32'd6, 32'd3, 3'b100, 32'd5, 1'b0, 1'b0, 1};
`endif
        vecs[7] = '{1'b0, 32'd1, 32'd4, 3'b101, 32'd16, 1'b0, 1'b0, 2};

        reset_n = 1'b0;
        set_req(1'b0, 1'b1, 32'd5, 32'd7, 3'b000);
        set_req(1'b1, 1'b1, 32'd1, 32'd2, 3'b110);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #12;
        chk_all_zero("reset");
        set_req(1'b0, 1'b0, '0, '0, 3'b000);
        set_req(1'b1, 1'b0, '0, '0, 3'b000);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Reset while a transaction is in EXEC
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 32'd5, 32'd7, 3'b000);
        @(negedge clk);
        chk("rst_hs_ready", W'(req0_ready), 1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, '0, '0, 3'b000);
        @(negedge clk);
        chk("rst_exec_busy", W'(busy), 1);
        reset_n = 1'b0;
        req0_valid = 1'b1;
        rsp0_ready = 1'b1;
        #1;
        chk_all_zero("rst_exec");
        @(negedge clk);
        req0_valid = 1'b0;
        rsp0_ready = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_after_busy", W'(busy), 0);
            chk("rst_after_rspv", W'(rsp0_valid), 0);
        end

        // Tie after reset: req0 first, then req1 wins the next tie, then req0 again
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 32'd9, 32'd9, 3'b001);
        set_req(1'b1, 1'b1, 32'd1, 32'd2, 3'b110);
        @(negedge clk);
        chk("tie1_ready0", W'(req0_ready), 1);
        chk("tie1_ready1", W'(req1_ready), 0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, '0, '0, 3'b000);
        @(negedge clk);
        chk("tie1_ctrl", W'(alu_control), 1);
        chk("tie1_exec_ready1", W'(req1_ready), 0);
        @(negedge clk);
        chk("tie1_rsp0v", W'(rsp0_valid), 1);
        chk("tie1_res", rsp0_result, 0);
        chk("tie1_zero", W'(rsp0_zero), 1);
        chk("tie1_resp_ready1", W'(req1_ready), 0);
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        set_req(1'b0, 1'b1, 32'd5, 32'd7, 3'b000);
        @(negedge clk);
        chk("tie2_ready1", W'(req1_ready), 1);
        chk("tie2_ready0", W'(req0_ready), 0);
        @(negedge clk);
        chk("tie2_ctrl", W'(alu_control), 6);
        chk("tie2_exec_ready0", W'(req0_ready), 0);
        @(negedge clk);
        chk("tie2_rsp1v", W'(rsp1_valid), 1);
        chk("tie2_res", rsp1_result, 3);
        chk("tie2_zero", W'(rsp1_zero), 0);
        rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp1_ready = 1'b0;
        @(negedge clk);
        chk("tie3_ready0", W'(req0_ready), 1);
        chk("tie3_ready1", W'(req1_ready), 0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, '0, '0, 3'b000);
        set_req(1'b1, 1'b0, '0, '0, 3'b000);
        @(negedge clk);
        chk("tie3_ctrl", W'(alu_control), 0);
        chk("tie3_a", alu_a, 5);
        @(negedge clk);
        chk("tie3_rsp0v", W'(rsp0_valid), 1);
        chk("tie3_res", rsp0_result, 12);
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        @(negedge clk);
        chk("tie3_done_busy", W'(busy), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have ports: clk  input  1  clock, all state on rising edge; reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have, for N in {0,1}: reqN_valid  input  1  request pending; reqN_ready  output  1  request accepted this cycle; reqN_a, reqN_b  input  WIDTH  operands; reqN_op  input  3  ALU control code.
REQ-004 SHALL have, for N in {0,1}: rspN_valid  output  1  result available; rspN_ready  input  1  requester takes result; rspN_result  output  WIDTH  result; rspN_zero  output  1  zero flag; rspN_err  output  1  rejected opcode.
REQ-005 SHALL have ALU-side ports: alu_a, alu_b  output  WIDTH  operands; alu_control  output  3  operation; alu_result  input  WIDTH; alu_zero  input  1 (combinational ALU assumed on these pins).
REQ-006 SHALL have busy  output  1: high whenever state is not IDLE.

Function
REQ-007 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-008 IDLE: grant computed combinationally; reqG_ready=1 only for granted G with reqG_valid=1; other ready=0; on handshake latch a, b, op, requester id, go EXEC.
REQ-009 Arbitration: one valid -> that one; both valid -> requester not in last_grant; last_grant updated on each handshake.
REQ-010 EXEC (exactly one cycle): drive latched operands/op on alu_*; capture alu_result, alu_zero into result registers at cycle end; go RESP.
REQ-011 alu_a, alu_b, alu_control SHALL hold latched values in EXEC and RESP, zero in IDLE.
REQ-012 RESP: rspG_valid=1 for latched requester only, result/zero/err stable until rspG_ready=1; on that edge go IDLE.
REQ-013 Latency: handshake at edge N -> rspG_valid high from edge N+2; minimum issue interval 3 cycles.
REQ-014 No request SHALL be accepted outside IDLE; reqN_ready=0 in EXEC and RESP regardless of reqN_valid.
REQ-015 Requester deasserting valid before handshake SHALL be dropped without effect; operands after handshake ignored.
REQ-016 rspN_ready asserted while rspN_valid=0 SHALL be ignored.
REQ-017 Non-granted rsp outputs SHALL be valid=0, result=0, zero=0, err=0.

Reset
REQ-018 reset_n=0 SHALL immediately force state IDLE, last_grant=1 (requester 0 wins first tie), all latched registers 0.
REQ-019 During reset all outputs SHALL be 0: readies, rsp*_valid, rsp*_result, rsp*_zero, rsp*_err, alu_*, busy.
REQ-020 Reset mid-EXEC or mid-RESP SHALL discard the transaction; no response delivered after release.
REQ-021 First handshake possible on first rising edge with reset_n=1.

Configuration
REQ-022 Macro ALU_ARBITER_OPCHECK_EN SHALL control opcode checking.
REQ-023 Defined: op 3'b100 or 3'b111 accepted but not dispatched; EXEC drives alu_* to 0; response result=0, zero=1, err=1; same latency.
REQ-024 Undefined: all opcodes dispatched unchanged; rspN_err tied 0.

Verification
REQ-025 Single op: req0 a=5 b=7 op=000 -> ready0 at edge 0, alu_control=000 edge 1, rsp0_valid edge 2, result=12, zero=0.
REQ-026 Tie after reset: both valid (req0 op=001 a=b=9, req1 op=110 a=1 b=2) -> req0 first (result 0, zero 1), then req1 (result 3); next tie grants req0 again only after req1 served.
REQ-027 Backpressure: rsp1_ready low 5 cycles -> rsp1_valid and result held, busy=1, req0_ready=0 throughout; completes on ready.
REQ-028 Reset in EXEC: assert reset_n=0 one cycle after handshake -> all outputs 0, no rsp after release, next request served normally.
REQ-029 Opcode check: op=3'b111 a=3 b=4 -> with macro result=0 zero=1 err=1, alu_control=0; without macro alu_control=111, err=0.
REQ-030 Withdrawn request: req1_valid pulsed during RESP of req0 then dropped -> req1 never granted, no rsp1_valid.
